// File: rtl/addatone_pkg.sv
// addatone_pkg: shared types and widths for the additive-synthesis mixing stage
package addatone_pkg;
  typedef enum logic [2:0] {SETTLE, IDLE, LOOKUP, MULTIPLY, ACCUMULATE, WAIT, OUTPUT} state_t;
  localparam int SINE_ADDR_W = 11;
  localparam int SINE_W = 16;
  localparam int ACC_W = 24;
  localparam int GAIN_W = 16;
  localparam logic [GAIN_W-1:0] GAIN_INIT = 16'hFFFF;
  function automatic logic [SINE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    return a > 24'sd32767 ? 16'h7FFF : a < -24'sd32768 ? 16'h8000 : a[SINE_W-1:0];
  endfunction
endpackage

// File: rtl/sine_lut.sv
// sine_lut: 2048x16 signed full-scale sine ROM with a registered read port
module sine_lut
  import addatone_pkg::*;
(
  input  logic                     clock,
  input  logic [SINE_ADDR_W-1:0]   addr,
  output logic signed [SINE_W-1:0] data
);
  localparam int DEPTH = 1 << SINE_ADDR_W;
  logic signed [SINE_W-1:0] rom [DEPTH];
  // table contents are computed at elaboration, rounded to nearest
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam real AMP = 32767.0 * $sin(6.283185307179586 * i / DEPTH);
    assign rom[i] = SINE_W'($rtoi(AMP < 0.0 ? AMP - 0.5 : AMP + 0.5));
  end
  always_ff @(posedge clock) data <= rom[addr];
endmodule

// File: rtl/harmonic_mixer.sv
// harmonic_mixer: sums N gain-decayed sine harmonics into one saturated sample per tick
module harmonic_mixer
  import addatone_pkg::*;
#(
  parameter int POS_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic [7:0]  harmonic_count,
  input  logic [7:0]  rolloff,
  input  logic [15:0] sample_position,
  output logic [7:0]  harmonic,
  output logic        next_sample,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        overrun
);
  state_t state, state_nx;
  logic [7:0] cnt, n_q, roll_q;
  logic [GAIN_W-1:0] gain;
  logic signed [ACC_W-1:0] acc;
  logic signed [SINE_W:0] term;
  logic signed [SINE_W-1:0] sine;
  logic signed [2*SINE_W:0] prod;
  logic last, cnt_done, start, consume, emit, late_tick, unused_bits;
  sine_lut u_lut (
    .clock(clock),
    .addr (sample_position[15:5]),
    .data (sine)
  );
  assign prod = 33'(sine) * 33'($signed({1'b0, gain}));
  assign last = harmonic == n_q - 8'd1;
  assign cnt_done = cnt == 8'd1;
  assign unused_bits = ^{sample_position[4:0], prod[15:0]};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= SETTLE;
    else state <= state_nx;
  end
  // harmonic is 0 in WAIT only after the last harmonic, so it selects frame end
  always_comb begin
    state_nx = state;
    case (state)
      SETTLE, WAIT: state_nx = cnt_done ? (harmonic == 8'd0 ? IDLE : LOOKUP) : state;
      IDLE:         state_nx = sample_tick ? LOOKUP : IDLE;
      LOOKUP:       state_nx = MULTIPLY;
      MULTIPLY:     state_nx = ACCUMULATE;
      ACCUMULATE:   state_nx = last ? OUTPUT : WAIT;
      OUTPUT:       state_nx = WAIT;
      default:      state_nx = SETTLE;
    endcase
  end
  always_comb begin
    start = state == IDLE && sample_tick;
    consume = state == ACCUMULATE;
    emit = state == OUTPUT;
    late_tick = state != IDLE && sample_tick;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 8'(POS_LATENCY);
      n_q <= 8'd1;
      roll_q <= '0;
      acc <= '0;
      gain <= GAIN_INIT;
      term <= '0;
      harmonic <= '0;
      next_sample <= 1'b0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= (consume || emit) ? 8'(POS_LATENCY) : (state == SETTLE || state == WAIT) ? cnt - 8'd1 : cnt;
      if (start) n_q <= harmonic_count == 8'd0 ? 8'd1 : harmonic_count;
      if (start) roll_q <= rolloff;
      acc <= start ? '0 : consume ? acc + ACC_W'(term) : acc;
      gain <= start ? GAIN_INIT : consume ? GAIN_W'((32'(gain) * 32'(roll_q)) >> 8) : gain;
      if (state == MULTIPLY) term <= prod[2*SINE_W:SINE_W];
      harmonic <= consume ? (last ? 8'd0 : harmonic + 8'd1) : harmonic;
      next_sample <= consume;
      sample_valid <= emit;
      if (emit) sample_out <= saturate(acc);
      overrun <= late_tick;
    end
  end
endmodule
